// File: rtl/layer_scheduler_pkg.sv
// Shared definitions for the layer scheduler slice.
//   state_t    : sequencer state encoding (3-bit)
//   LAST_BIT   : descriptor bit marking the final layer of a run
//   RELOAD_BIT : descriptor bit requesting a weight load before the layer
//   idx_w()    : index width for a table of n entries (never below 1)
package layer_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CONFIG = 3'd2,
        RUN    = 3'd3,
        NEXT   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int unsigned LAST_BIT   = 0;
    localparam int unsigned RELOAD_BIT = 1;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_scheduler_desc_table.sv
// layer_desc_table: descriptor register file, one entry per layer.
// Ports:
//   clk1, rst_n : clock, asynchronous active-low reset (clears every entry)
//   we          : write enable (the caller gates this to IDLE)
//   waddr/wdata : write index/data; indices >= NUM_LAYERS are dropped
//   raddr       : combinational read index
//   rdata       : entry at raddr (0 for an out-of-range index)
module layer_desc_table
    import layer_scheduler_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned CFG_W      = 16,
    parameter int unsigned IDX_W      = idx_w(NUM_LAYERS)
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [CFG_W-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [CFG_W-1:0] rdata
);

    logic [CFG_W-1:0] mem [NUM_LAYERS];

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (32'(waddr) < NUM_LAYERS)) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (32'(raddr) < NUM_LAYERS) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/layer_scheduler.sv
// layer_scheduler: walks the descriptor table one layer at a time, doing an
// optional weight-load handshake, then starting the conv controller and
// waiting for its completion edge. Pulses done after the last layer.
// Ports:
//   clk1, rst_n          : clock, asynchronous active-low reset
//   start, abort         : run request (IDLE only) / synchronous abort
//   cfg_we/addr/wdata    : descriptor table write port (accepted in IDLE)
//   load_req, load_layer : weight-load request and its layer index
//   load_ack             : loader completion pulse
//   start_conv, end_conv : conv controller start pulse / completion level
//   cfg_out, layer_idx   : descriptor and index of the active layer
//   busy, done, err      : not-IDLE, end-of-run pulse, sticky watchdog error
// Optional: `define LAYER_SCHED_WATCHDOG_EN adds a TIMEOUT_W-bit RUN watchdog;
// without it err stays 0 and RUN waits indefinitely.
module layer_scheduler
    import layer_scheduler_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned CFG_W      = 16,
    parameter int unsigned TIMEOUT_W  = 16
) (
    input  logic                             clk1,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             cfg_we,
    input  logic [idx_w(NUM_LAYERS)-1:0]     cfg_addr,
    input  logic [CFG_W-1:0]                 cfg_wdata,
    output logic                             load_req,
    output logic [idx_w(NUM_LAYERS)-1:0]     load_layer,
    input  logic                             load_ack,
    output logic                             start_conv,
    input  logic                             end_conv,
    output logic [CFG_W-1:0]                 cfg_out,
    output logic [idx_w(NUM_LAYERS)-1:0]     layer_idx,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);

    localparam int unsigned      IDX_W    = idx_w(NUM_LAYERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic             err_q, err_d;
    logic             ec_q;
    logic             ec_rise;
    logic             wd_expire;
    logic             tbl_we;
    logic [IDX_W-1:0] rd_addr;
    logic [CFG_W-1:0] rd_data;

    assign ec_rise = end_conv & ~ec_q;
    assign tbl_we  = cfg_we && (state_q == IDLE);

    // The single read port serves three lookups: entry 0 when a run is
    // accepted, the following entry in NEXT, and the active entry in CONFIG.
    always_comb begin
        rd_addr = idx_q;
        if (state_q == IDLE) begin
            rd_addr = '0;
        end else if (state_q == NEXT) begin
            rd_addr = idx_q + IDX_W'(1);
        end
    end

    layer_desc_table #(
        .NUM_LAYERS (NUM_LAYERS),
        .CFG_W      (CFG_W),
        .IDX_W      (IDX_W)
    ) u_table (
        .clk1  (clk1),
        .rst_n (rst_n),
        .we    (tbl_we),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

`ifdef LAYER_SCHED_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] wd_q;

    // Held at zero outside RUN so every RUN entry starts from a clean count.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else if (state_q != RUN) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + TIMEOUT_W'(1);
        end
    end

    // Fires in the RUN cycle whose increment would reach all-ones.
    assign wd_expire = (state_q == RUN) && (wd_q == ~TIMEOUT_W'(1));
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cfg_d   = cfg_q;
        err_d   = err_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_d   = '0;
                        err_d   = 1'b0;
                        state_d = rd_data[RELOAD_BIT] ? LOAD : CONFIG;
                    end
                end
                LOAD: begin
                    if (load_ack) begin
                        state_d = CONFIG;
                    end
                end
                CONFIG: begin
                    cfg_d   = rd_data;
                    state_d = RUN;
                end
                RUN: begin
                    if (ec_rise) begin
                        state_d = NEXT;
                    end else if (wd_expire) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
                NEXT: begin
                    if (cfg_q[LAST_BIT] || (idx_q == LAST_IDX)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = rd_data[RELOAD_BIT] ? LOAD : CONFIG;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output strobes are registered from the next state so that they line
    // up with the state they belong to; abort therefore clears them at once.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cfg_q      <= '0;
            err_q      <= 1'b0;
            ec_q       <= 1'b0;
            load_req   <= 1'b0;
            start_conv <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cfg_q      <= cfg_d;
            err_q      <= err_d;
            ec_q       <= end_conv;
            load_req   <= (state_d == LOAD);
            start_conv <= (state_q == CONFIG) && (state_d == RUN);
            busy       <= (state_d != IDLE);
            done       <= (state_d == DONE);
        end
    end

    assign load_layer = idx_q;
    assign layer_idx  = idx_q;
    assign cfg_out    = cfg_q;
    assign err        = err_q;

endmodule

// File: doc/layer_scheduler.md
Name: layer_scheduler

Overview:
- Top-level sequencer for the convolution engine. Walks a small descriptor table, one entry per layer.
- Per layer: optional weight-load handshake with the DMA/loader, then latch the layer configuration, pulse start_conv to the conv controller, and wait for its end_conv.
- Sits between the host/config interface and the conv controller; raises done after the last layer.

Parameters:
NUM_LAYERS, 4, descriptor table depth (max layers per run); >=1
CFG_W, 16, descriptor width; bit0 = LAST, bit1 = RELOAD_WGT, bits [CFG_W-1:2] opaque, forwarded to the datapath
TIMEOUT_W, 16, watchdog counter width (used only with the optional feature)

Ports:
clk1  in  1  single clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  run request; sampled in IDLE only
abort  in  1  synchronous abort; returns to IDLE from any state
cfg_we  in  1  descriptor table write enable
cfg_addr  in  $clog2(NUM_LAYERS) (min 1)  table write index
cfg_wdata  in  CFG_W  descriptor data
load_req  out  1  weight-load request to loader
load_layer  out  $clog2(NUM_LAYERS) (min 1)  layer index for the load
load_ack  in  1  loader completion, 1-cycle pulse
start_conv  out  1  1-cycle pulse to conv controller
end_conv  in  1  conv controller completion (level; rising edge is the event)
cfg_out  out  CFG_W  descriptor of the active layer
layer_idx  out  $clog2(NUM_LAYERS) (min 1)  active layer index
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse at end of run
err  out  1  sticky watchdog error (0 when feature off)

Behaviour:
- Reset: state=IDLE; all outputs 0; table entries 0; end_conv edge register 0. All outputs are registered.
- Table: written only when cfg_we=1 and state=IDLE. Writes while busy are dropped. cfg_addr >= NUM_LAYERS is ignored.
- States: IDLE, LOAD, CONFIG, RUN, NEXT, DONE.
- IDLE: start=1 -> layer_idx<=0, clear err. Go to LOAD if table[0].RELOAD_WGT=1, else CONFIG.
- LOAD: load_req=1 and load_layer=layer_idx, held until load_ack is sampled high. Then load_req<=0 and go to CONFIG. load_ack outside LOAD is ignored.
- CONFIG: one cycle. cfg_out<=table[layer_idx]; start_conv<=1; go to RUN.
- RUN: start_conv is high only on the first RUN cycle. A rising edge of end_conv (end_conv=1 and previous sample=0) in any RUN cycle, including the first, goes to NEXT.
- NEXT: if cfg_out.LAST=1 or layer_idx==NUM_LAYERS-1, go to DONE. Otherwise layer_idx++ and go to LOAD or CONFIG per the next entry's RELOAD_WGT.
- DONE: done=1 for one cycle, then IDLE. cfg_out and layer_idx hold their last values.
- Latency: start at edge 0 with RELOAD_WGT=0 -> CONFIG after edge 1 -> start_conv high after edge 2. Edge of end_conv -> next layer's start_conv 3 cycles later (NEXT, CONFIG, RUN) when no reload.
- abort: takes priority over every transition. Next edge gives state=IDLE with load_req, start_conv and busy cleared; done is not pulsed. layer_idx, cfg_out and err hold.
- start while busy: ignored. start and abort in the same IDLE cycle: stay IDLE.
- Asynchronous reset mid-run: immediate return to reset values. The table is also cleared, so the host must rewrite it.

Optional Feature:
- Macro LAYER_SCHED_WATCHDOG_EN.
- Defined: a TIMEOUT_W-bit counter clears on RUN entry and increments each RUN cycle. On reaching all-ones without an end_conv edge: err<=1 (sticky until the next accepted start), go to DONE (done pulses).
- Undefined: no counter; RUN waits indefinitely; err tied 0.

Decomposition:
- Shared package holds:
  - state encoding constants (3-bit);
  - descriptor bit positions LAST_BIT=0, RELOAD_BIT=1;
  - the index-width function.
- One natural sub-module: layer_desc_table, a register file with a write port and a combinational read port indexed by layer_idx.

Test Plan:
- 2-layer run: table[0]=0x0000, table[1]=0x0003, start -> start_conv at cycles 2 and later; load_req asserted before layer 1 until load_ack; done 1 cycle after the second end_conv edge +1; layer_idx=1 at end.
- LAST flag: table[0]=0x0001 with NUM_LAYERS=4 -> single start_conv, done, layer_idx=0.
- Full table with no LAST -> exactly 4 start_conv pulses, layer_idx wraps to no further value, done once.
- abort asserted in LOAD with load_req=1 -> next cycle load_req=0, busy=0, no done; a later start restarts at layer 0.
- cfg_we while busy with addr 0, data 0xFFFF -> table unchanged (second run behaves identically); end_conv held high across RUN entry of the next layer -> no false advance until it falls and rises again.
- With LAYER_SCHED_WATCHDOG_EN and TIMEOUT_W=4, end_conv held 0 -> err=1 and done after 15 RUN cycles; next start clears err.
